// File: rtl/cpu_pkg.sv
// Shared encodings for the store path: store sizes, RMW state machine states, byte-lane width.
package cpu_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10
  } state_e;

endpackage

// File: rtl/byte_merge.sv
// Combinational little-endian lane merge: drops new byte/halfword data into an old word.
module byte_merge
  import cpu_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    if (size_i == SZ_WORD) begin
      merged_o = new_i;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (size_i == SZ_BYTE && off_i == k[1:0])
          merged_o[k*LANE_W +: LANE_W] = new_i[LANE_W-1:0];
        // Halfword lanes come from the low 16 bits, lower lane first.
        if (size_i == SZ_HALF && off_i[1] == k[1])
          merged_o[k*LANE_W +: LANE_W] = new_i[(k%2)*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store path into the word-only data RAM: sw writes directly, sb/sh do a 3-cycle
// read-modify-write while holding the PC through the stall output.
module store_rmw_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              store_req,
  input  logic              Byte,
  input  logic              Half,
  input  logic [31:0]       Addr,
  input  logic [31:0]       R2_out,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              stall,
  output logic              misalign
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] a_q;
  logic [1:0]        off_q;
  size_e             size_q;
  logic [31:0]       data_q;
  logic [31:0]       wbuf_q;
  logic [31:0]       merged;
  size_e             size_in;
  logic              mis_in;
  logic              start_rmw;
  logic              unused_addr;

  assign unused_addr = ^Addr[31:ADDR_W+2];

  assign size_in = Byte ? SZ_BYTE : (Half ? SZ_HALF : SZ_WORD);
  assign mis_in  = (size_in == SZ_HALF && Addr[0]) ||
                   (size_in == SZ_WORD && Addr[1:0] != 2'b00);
  assign start_rmw = (state_q == ST_IDLE) && store_req && !mis_in && (size_in != SZ_WORD);

  byte_merge u_merge (
    .old_i    (mem_rdata),
    .new_i    (data_q),
    .off_i    (off_q),
    .size_i   (size_q),
    .merged_o (merged)
  );

  always_comb begin
    mem_addr  = Addr[ADDR_W+1:2];
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 32'h0;
    stall     = 1'b0;
    misalign  = 1'b0;
    state_d   = state_q;
    case (state_q)
      ST_IDLE: begin
        if (store_req) begin
          if (mis_in) begin
            misalign = 1'b1;
          end else if (size_in == SZ_WORD) begin
            mem_we    = 1'b1;
            mem_wdata = R2_out;
          end else begin
            mem_re  = 1'b1;
            stall   = 1'b1;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        mem_addr = a_q;
        stall    = 1'b1;
        state_d  = ST_WR;
      end
      ST_WR: begin
        // No stall here: the PC advances on this edge together with the write.
        mem_addr  = a_q;
        mem_we    = 1'b1;
        mem_wdata = wbuf_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = 32'h0;
      stall     = 1'b0;
      misalign  = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      off_q   <= 2'b00;
      size_q  <= SZ_WORD;
      data_q  <= 32'h0;
      wbuf_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (start_rmw) begin
        a_q    <= Addr[ADDR_W+1:2];
        off_q  <= Addr[1:0];
        size_q <= size_in;
        data_q <= R2_out;
      end
      if (state_q == ST_RD)
        wbuf_q <= merged;
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit with a behavioural RAM and a per-store cycle model.
module tb_store_rmw_unit;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              store_req;
  logic              Byte;
  logic              Half;
  logic [31:0]       Addr;
  logic [31:0]       R2_out;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              stall;
  logic              misalign;

  always #5 clk = ~clk;

  store_rmw_unit #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .store_req (store_req),
    .Byte      (Byte),
    .Half      (Half),
    .Addr      (Addr),
    .R2_out    (R2_out),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .stall     (stall),
    .misalign  (misalign)
  );

  logic [31:0] ram     [0:(1<<ADDR_W)-1];
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  logic              chk_en = 1'b0;
  logic              e_re, e_we, e_stall, e_mis;
  logic              e_addr_chk, e_wdata_chk;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0]       e_wdata;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check32("mem_re",   {31'b0, mem_re},   {31'b0, e_re});
      check32("mem_we",   {31'b0, mem_we},   {31'b0, e_we});
      check32("stall",    {31'b0, stall},    {31'b0, e_stall});
      check32("misalign", {31'b0, misalign}, {31'b0, e_mis});
      if (e_addr_chk)  check32("mem_addr", {22'b0, mem_addr}, {22'b0, e_addr});
      if (e_wdata_chk) check32("mem_wdata", mem_wdata, e_wdata);
    end
  end

  // Reference merge by mask-and-shift on the whole word.
  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [31:0] addr, input logic b, input logic h);
    int          sh;
    logic [31:0] mask;
    if (b) begin
      sh   = 8 * int'(addr[1:0]);
      mask = 32'hFF << sh;
      return (old & ~mask) | ((data & 32'hFF) << sh);
    end else if (h) begin
      sh   = 16 * int'(addr[1]);
      mask = 32'hFFFF << sh;
      return (old & ~mask) | ((data & 32'hFFFF) << sh);
    end
    return data;
  endfunction

  task automatic clear_exp();
    e_re = 1'b0; e_we = 1'b0; e_stall = 1'b0; e_mis = 1'b0;
    e_addr_chk = 1'b0; e_wdata_chk = 1'b0; e_addr = '0; e_wdata = 32'h0;
  endtask

  task automatic idle(input int n);
    store_req = 1'b0; Byte = 1'b0; Half = 1'b0; rst = 1'b0;
    clear_exp();
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // rst_cycle < 0: no reset; otherwise reset is asserted in that cycle and the store aborts.
  task automatic run_store(input logic b, input logic h, input logic [31:0] addr,
                           input logic [31:0] data, input int rst_cycle);
    logic              word, mis;
    int                n;
    logic [ADDR_W-1:0] wa;
    logic [31:0]       newv;
    word = !b && !h;
    mis  = (!b && h && addr[0]) || (word && addr[1:0] != 2'b00);
    n    = (mis || word) ? 1 : 3;
    wa   = addr[ADDR_W+1:2];
    newv = model_merge(ref_mem[wa], data, addr, b, h);
    for (int c = 0; c < n; c++) begin
      store_req = 1'b1; Byte = b; Half = h; Addr = addr; R2_out = data;
      rst = (c == rst_cycle);
      clear_exp();
      e_addr_chk = 1'b1; e_addr = wa;
      if (rst) begin
        e_addr_chk = 1'b0; e_wdata_chk = 1'b1;
      end else if (mis) begin
        e_mis = 1'b1;
      end else if (word) begin
        e_we = 1'b1; e_wdata_chk = 1'b1; e_wdata = data;
      end else if (c == 0) begin
        e_re = 1'b1; e_stall = 1'b1;
      end else if (c == 1) begin
        e_stall = 1'b1;
      end else begin
        e_we = 1'b1; e_wdata_chk = 1'b1; e_wdata = newv;
      end
      @(posedge clk); #1;
      if (c == rst_cycle) begin
        rst = 1'b0;
        return;
      end
    end
    if (!mis) ref_mem[wa] = newv;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = 32'h0;
    Byte = 1'b0; Half = 1'b0; Addr = 32'h10; R2_out = 32'h12345678;

    // Reset held two cycles with a store request pending: nothing may happen.
    rst = 1'b1; store_req = 1'b1;
    clear_exp();
    e_wdata_chk = 1'b1;
    chk_en = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    idle(1);

    run_store(1'b0, 1'b0, 32'h10, 32'hDEADBEEF, -1);
    check32("ram4_sw", ram[4], 32'hDEADBEEF);

    run_store(1'b0, 1'b0, 32'h10, 32'h11223344, -1);
    run_store(1'b1, 1'b0, 32'h12, 32'h000000AB, -1);
    check32("ram4_sb", ram[4], 32'h11AB3344);
    check32("model_sb", ref_mem[4], 32'h11AB3344);

    run_store(1'b0, 1'b0, 32'h10, 32'h11223344, -1);
    run_store(1'b0, 1'b1, 32'h12, 32'hFFFFCAFE, -1);
    check32("ram4_sh_hi", ram[4], 32'hCAFE3344);

    run_store(1'b0, 1'b0, 32'h10, 32'h11223344, -1);
    run_store(1'b0, 1'b1, 32'h10, 32'hFFFFCAFE, -1);
    check32("ram4_sh_lo", ram[4], 32'h1122CAFE);
    idle(1);

    run_store(1'b0, 1'b1, 32'h13, 32'h0000BBBB, -1);
    run_store(1'b0, 1'b0, 32'h12, 32'hCCCCCCCC, -1);
    idle(1);
    check32("ram4_misaligned", ram[4], 32'h1122CAFE);

    // Byte outranks Half, so offset 3 is legal.
    run_store(1'b1, 1'b1, 32'h13, 32'h00000077, -1);
    check32("ram4_byte_prio", ram[4], 32'h7722CAFE);

    // Back-to-back RMWs with no gap; the second must see the first's result.
    run_store(1'b1, 1'b0, 32'h10, 32'h00000001, -1);
    run_store(1'b0, 1'b1, 32'h12, 32'h0000BEEF, -1);
    check32("ram4_b2b", ram[4], 32'hBEEFCA01);
    check32("model_b2b", ref_mem[4], 32'hBEEFCA01);

    // Reset in the RD cycle aborts the store; the next cycle must be plain IDLE.
    run_store(1'b0, 1'b0, 32'h10, 32'h11223344, -1);
    run_store(1'b1, 1'b0, 32'h12, 32'h000000AB, 1);
    idle(2);
    check32("ram4_abort", ram[4], 32'h11223344);
    run_store(1'b0, 1'b0, 32'h14, 32'hA5A5A5A5, -1);
    idle(1);
    check32("ram5_after_abort", ram[5], 32'hA5A5A5A5);
    check32("ram4_still", ram[4], 32'h11223344);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
